register_fifo: RTL and testbench

REGISTER_FIFO -- requirements
Module: register_fifo

---
 rtl/register_fifo.sv | 74 +++++++
 tb/tb_register_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/register_fifo.sv
// Register-based synchronous FIFO with registered read data, registered
// full/empty/count flags and one-cycle overflow/underflow pulses.
module register_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           d_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           q_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_wr, do_rd;

    // A write into a full FIFO is legal only when a read frees a slot on the same edge.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || rd_en);

    always_comb begin
        cnt_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   cnt_nxt = count + CNT_W'(1);
            2'b01:   cnt_nxt = count - CNT_W'(1);
            default: cnt_nxt = count;
        endcase
    end

    // Storage is never cleared; empty masks any stale words after reset.
    always_ff @(posedge clk) begin
        if (rst_n && do_wr)
            mem[wr_ptr] <= d_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            q_out     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + PTR_W'(1);
            // Old contents are read, so a same-edge write to this slot is never bypassed.
            if (do_rd) begin
                q_out  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= cnt_nxt;
            empty     <= (cnt_nxt == '0);
            full      <= (cnt_nxt == FULL_CNT);
            overflow  <= wr_en && full && !rd_en;
            underflow <= rd_en && empty;
        end
    end

endmodule

// File: tb/tb_register_fifo.sv
// Directed bench for register_fifo (WIDTH=10, DEPTH=4) with hand-computed
// expectations checked by immediate assertions.
module tb_register_fifo;

    localparam int WIDTH = 10;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en, rd_en;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] q_out;
    logic             full, empty, overflow, underflow;
    logic [2:0]       count;

    int errors = 0;
    int checks = 0;

    register_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .d_in      (d_in),
        .rd_en     (rd_en),
        .q_out     (q_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r);
        wr_en = w;
        d_in  = d;
        rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        d_in  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b1, 10'h3A5, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        d_in  = '0;
        step(1'b0, '0, 1'b0);
        do_reset();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_q", q_out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);

        // Basic ordering
        step(1'b1, 10'h001, 1'b0);
        step(1'b1, 10'h002, 1'b0);
        step(1'b1, 10'h003, 1'b0);
        check("ord_count3", count, 3);
        step(1'b0, '0, 1'b1);
        check("ord_q1", q_out, 10'h001);
        step(1'b0, '0, 1'b1);
        check("ord_q2", q_out, 10'h002);
        step(1'b0, '0, 1'b1);
        check("ord_q3", q_out, 10'h003);
        check("ord_empty", empty, 1);
        check("ord_count0", count, 0);

        // Fill, overflow, drain
        step(1'b1, 10'h3FF, 1'b0);
        step(1'b1, 10'h155, 1'b0);
        step(1'b1, 10'h2AA, 1'b0);
        step(1'b1, 10'h0F0, 1'b0);
        check("fill_full", full, 1);
        check("fill_count", count, 4);
        check("fill_empty", empty, 0);
        step(1'b1, 10'h111, 1'b0);
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 4);
        check("ovf_q_hold", q_out, 10'h003);
        step(1'b0, '0, 1'b0);
        check("ovf_clear", overflow, 0);
        step(1'b0, '0, 1'b1);
        check("drain_q0", q_out, 10'h3FF);
        check("drain_notfull", full, 0);
        step(1'b0, '0, 1'b1);
        check("drain_q1", q_out, 10'h155);
        step(1'b0, '0, 1'b1);
        check("drain_q2", q_out, 10'h2AA);
        step(1'b0, '0, 1'b1);
        check("drain_q3", q_out, 10'h0F0);
        check("drain_empty", empty, 1);

        // Simultaneous write and read while full
        for (int i = 0; i < 4; i++)
            step(1'b1, 10'h010 + 10'(i), 1'b0);
        check("sim_full_pre", full, 1);
        step(1'b1, 10'h020, 1'b1);
        check("sim_q", q_out, 10'h010);
        check("sim_count", count, 4);
        check("sim_full", full, 1);
        check("sim_no_ovf", overflow, 0);
        step(1'b0, '0, 1'b1);
        check("sim_r1", q_out, 10'h011);
        step(1'b0, '0, 1'b1);
        check("sim_r2", q_out, 10'h012);
        step(1'b0, '0, 1'b1);
        check("sim_r3", q_out, 10'h013);
        step(1'b0, '0, 1'b1);
        check("sim_r4", q_out, 10'h020);
        check("sim_empty", empty, 1);

        // Underflow with a simultaneous accepted write
        do_reset();
        step(1'b1, 10'h07B, 1'b1);
        check("unf_pulse", underflow, 1);
        check("unf_q", q_out, 10'h000);
        check("unf_count", count, 1);
        step(1'b0, '0, 1'b1);
        check("unf_read", q_out, 10'h07B);
        check("unf_clear", underflow, 0);
        check("unf_empty", empty, 1);

        // Pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 10'h100 + 10'(i), 1'b0);
            check("wrap_count1", count, 1);
            step(1'b0, '0, 1'b1);
            check("wrap_q", q_out, 10'h100 + 10'(i));
            check("wrap_count0", count, 0);
        end

        // Reset mid-operation
        step(1'b1, 10'h00A, 1'b0);
        step(1'b1, 10'h00B, 1'b0);
        step(1'b1, 10'h00C, 1'b0);
        check("mid_count3", count, 3);
        do_reset();
        check("mid_count", count, 0);
        check("mid_empty", empty, 1);
        check("mid_full", full, 0);
        check("mid_q", q_out, 10'h000);
        step(1'b0, '0, 1'b1);
        check("mid_unf", underflow, 1);
        check("mid_q_hold", q_out, 10'h000);
        step(1'b0, '0, 1'b0);
        check("mid_unf_clear", underflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
